crc_sequencer: RTL and testbench

- Controller for the bit-serial CRC engine (crc_create).
- Accepts a message of msg_len parallel bytes over a valid/ready stream and serializes each byte MSB-first into the engine.
- Drives the engine's init/enable/bit_in and captures the final CRC with a done pulse.
- Sits between the CAN frame builder and the CRC engine, so frame logic never hand-sequences bits.

---
 rtl/crc_sequencer.sv | 151 +++++++++++++++
 tb/tb_crc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc_sequencer.sv
// Sequencer that feeds parallel message words MSB-first into a bit-serial CRC
// engine and captures the final CRC with a one-cycle done pulse.
module crc_sequencer #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              crc_init,
  output logic              crc_enable,
  output logic              crc_bit,
  input  logic [CRC_W-1:0]  crc_value,
  output logic              done,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] shreg_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0]  bit_cnt_s;
  logic [LEN_W-1:0]  words_left_r;
  logic [LEN_W-1:0]  words_left_s;

  // Next-state, shift register and counter update; abort overrides every non-idle transition.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    bit_cnt_s    = bit_cnt_r;
    words_left_s = words_left_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          words_left_s = msg_len;
          state_s      = S_INIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (words_left_r != {LEN_W{1'b0}}) begin
          state_s = S_LOAD;
        end else begin
          state_s = S_SETTLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (in_valid) begin
          shreg_s   = in_data;
          bit_cnt_s = BIT_LAST;
          state_s   = S_SHIFT;
        end else begin
          state_s = S_LOAD;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_s = S_IDLE;
        end else begin
          shreg_s   = shreg_r << 1;
          bit_cnt_s = bit_cnt_r - CNT_W'(1);
          if (bit_cnt_r == {CNT_W{1'b0}}) begin
            words_left_s = words_left_r - LEN_W'(1);
            state_s      = (words_left_r == LEN_W'(1)) ? S_SETTLE : S_LOAD;
          end else begin
            state_s = S_SHIFT;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      shreg_r      <= {DATA_W{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      words_left_r <= {LEN_W{1'b0}};
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      bit_cnt_r    <= bit_cnt_s;
      words_left_r <= words_left_s;
    end
  end

  // Outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      crc_init   <= 1'b0;
      crc_enable <= 1'b0;
      crc_bit    <= 1'b0;
      done       <= 1'b0;
      crc_out    <= {CRC_W{1'b0}};
    end else begin
      in_ready   <= (state_s == S_LOAD);
      busy       <= (state_s != S_IDLE);
      crc_init   <= (state_s == S_INIT);
      crc_enable <= (state_s == S_SHIFT);
      crc_bit    <= (state_s == S_SHIFT) ? shreg_s[DATA_W-1] : 1'b0;
      done       <= (state_s == S_DONE);
      // The engine has absorbed the last bit by SETTLE, so crc_value is final there.
      if ((state_r == S_SETTLE) && !abort) begin
        crc_out <= crc_value;
      end else begin
        crc_out <= crc_out;
      end
    end
  end

endmodule

// File: tb/tb_crc_sequencer.sv
// Directed bench for crc_sequencer with a CRC-8 (poly 0x07, seed 0xFF) engine model.
module tb_crc_sequencer;

  localparam logic [7:0] SEED = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] msg_len = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, busy, crc_init, crc_enable, crc_bit, done;
  logic [7:0] crc_value, crc_out;
  logic [7:0] eng_r = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  crc_sequencer #(.DATA_W(8), .CRC_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .crc_init(crc_init), .crc_enable(crc_enable), .crc_bit(crc_bit),
    .crc_value(crc_value), .done(done), .crc_out(crc_out)
  );

  always #5 clk = ~clk;

  // Bit-serial engine model
  assign crc_value = eng_r;
  always @(posedge clk) begin
    if (crc_init) eng_r <= SEED;
    else if (crc_enable) eng_r <= {eng_r[6:0], 1'b0} ^ (((eng_r[7] ^ crc_bit) != 1'b0) ? 8'h07 : 8'h00);
  end

  typedef struct {
    logic [7:0]  len;
    logic [31:0] words;   // word i = words[31-8*(i%4) -: 8]
    logic [15:0] gaps;    // idle in_ready cycles before word i = gaps[15-4*(i%4) -: 4]
    logic        spam;    // pulse start throughout the message
    int          exp_done;
    logic [7:0]  exp_crc;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] word_of(input vec_t v, input int i);
    return v.words[31 - 8 * (i % 4) -: 8];
  endfunction

  function automatic int gap_of(input vec_t v, input int i);
    return int'(v.gaps[15 - 4 * (i % 4) -: 4]);
  endfunction

  function automatic logic [7:0] crc_ref(input vec_t v);
    logic [7:0] c = SEED;
    logic [7:0] w;
    for (int i = 0; i < int'(v.len); i++) begin
      w = word_of(v, i);
      for (int b = 7; b >= 0; b--) begin
        c = {c[6:0], 1'b0} ^ (((c[7] ^ w[b]) != 1'b0) ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0, idx = 0, waitc = 0;
    int n_init = 0, init_cyc = -1, first_rdy = -1, first_en = -1;
    int n_en = 0, bit_err = 0, n_done = 0, done_cyc = -1;
    logic [7:0] done_crc = 8'h00;
    logic [7:0] w;
    logic busy_after = 1'b1;
    start = 1'b1;
    msg_len = v.len;
    while (cyc < v.exp_done + 20) begin
      @(negedge clk);
      cyc++;
      start = v.spam && (cyc < v.exp_done);
      if (done_cyc >= 0) begin
        busy_after = busy;
        start = 1'b0;
        break;
      end
      if (crc_init) begin n_init++; init_cyc = cyc; end
      if (in_ready && first_rdy < 0) first_rdy = cyc;
      if (crc_enable) begin
        if (first_en < 0) first_en = cyc;
        w = word_of(v, n_en / 8);
        if (crc_bit !== w[7 - (n_en % 8)]) bit_err++;
        n_en++;
      end
      if (done) begin n_done++; done_cyc = cyc; done_crc = crc_out; end
      if (in_ready) begin
        if (waitc < gap_of(v, idx)) begin
          in_valid = 1'b0;
          waitc++;
        end else begin
          in_valid = 1'b1;
          in_data = word_of(v, idx);
          idx++;
          waitc = 0;
        end
      end else begin
        in_valid = 1'b0;
        in_data = 8'h00;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    check({tag, " init_count"}, 32'(n_init), 32'd1);
    check({tag, " init_cycle"}, 32'(init_cyc), 32'd1);
    check({tag, " first_ready"}, 32'(first_rdy), (v.len != 8'd0) ? 32'd2 : 32'hFFFF_FFFF);
    check({tag, " first_enable"}, 32'(first_en),
          (v.len != 8'd0) ? 32'(3 + gap_of(v, 0)) : 32'hFFFF_FFFF);
    check({tag, " enable_count"}, 32'(n_en), 32'(8 * int'(v.len)));
    check({tag, " bit_errors"}, 32'(bit_err), 32'd0);
    check({tag, " done_count"}, 32'(n_done), 32'd1);
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    check({tag, " crc_out"}, 32'(done_crc), 32'(v.exp_crc));
    check({tag, " busy_after"}, 32'(busy_after), 32'd0);
  endtask

  // Runs n cycles counting done and enable pulses, with all inputs idle.
  task automatic idle_watch(input int n, output int n_done, output int n_en);
    n_done = 0;
    n_en = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (crc_enable) n_en++;
    end
  endtask

  initial begin
    int nd, ne, cyc;
    logic [7:0] prev_crc;

    tbl[0] = '{len: 8'd1,   words: 32'hA200_0000, gaps: 16'h0000, spam: 1'b0, exp_done: 12,   exp_crc: 8'h94};
    tbl[1] = '{len: 8'd3,   words: 32'h1234_5600, gaps: 16'h0400, spam: 1'b0, exp_done: 34,   exp_crc: 8'h00};
    tbl[2] = '{len: 8'd0,   words: 32'h0000_0000, gaps: 16'h0000, spam: 1'b0, exp_done: 3,    exp_crc: SEED};
    tbl[3] = '{len: 8'd2,   words: 32'hFF00_0000, gaps: 16'h0000, spam: 1'b0, exp_done: 21,   exp_crc: 8'h00};
    tbl[4] = '{len: 8'd1,   words: 32'h0000_0000, gaps: 16'h2000, spam: 1'b0, exp_done: 14,   exp_crc: 8'h00};
    tbl[5] = '{len: 8'd2,   words: 32'h3C5A_0000, gaps: 16'h0000, spam: 1'b1, exp_done: 21,   exp_crc: 8'h00};
    tbl[6] = '{len: 8'd255, words: 32'h0123_4567, gaps: 16'h0000, spam: 1'b0, exp_done: 2298, exp_crc: 8'h00};
    for (int i = 1; i < 7; i++) begin
      if (i != 2) tbl[i].exp_crc = crc_ref(tbl[i]);
    end
    check("ref_model_a2", 32'(crc_ref(tbl[0])), 32'h94);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({in_ready, busy, crc_init, crc_enable, crc_bit, done, crc_out}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1; msg_len = 8'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_init", 32'(crc_init), 32'd1);
    cyc = 1;
    while (!done && cyc < 10) begin @(negedge clk); cyc++; end
    check("start_abort_done_cycle", 32'(cyc), 32'd3);
    check("start_abort_crc", 32'(crc_out), 32'(SEED));
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Abort in the 4th SHIFT cycle of a two-word message
    prev_crc = crc_out;
    start = 1'b1; msg_len = 8'd2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (c == 2);
      in_data = 8'h12;
    end
    check("abort_shift_enable", 32'(crc_enable), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_shift_busy", 32'(busy), 32'd0);
    check("abort_shift_outs", 32'({in_ready, crc_init, crc_enable, crc_bit, done}), 32'd0);
    idle_watch(20, nd, ne);
    check("abort_shift_no_done", 32'(nd), 32'd0);
    check("abort_shift_crc_held", 32'(crc_out), 32'(prev_crc));
    run_vec(tbl[0], "after_abort");

    // Abort in LOAD with in_valid in the same cycle
    start = 1'b1; msg_len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_load_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'hA2; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("abort_load_outs", 32'({busy, in_ready, crc_enable}), 32'd0);
    idle_watch(15, nd, ne);
    check("abort_load_no_enable", 32'(ne), 32'd0);
    check("abort_load_no_done", 32'(nd), 32'd0);

    // Reset mid-SHIFT clears everything, including the captured CRC
    start = 1'b1; msg_len = 8'd1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (c == 2);
      in_data = 8'hA2;
    end
    check("rst_mid_shift_enable", 32'(crc_enable), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_shift_outs", 32'({in_ready, busy, crc_init, crc_enable, crc_bit, done, crc_out}), 32'd0);
    rst = 1'b1;
    idle_watch(15, nd, ne);
    check("rst_mid_shift_no_done", 32'(nd), 32'd0);
    run_vec(tbl[3], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
